// File: rtl/reduce_tree_pkg.sv
// reduce_tree_pkg: op encoding and tree-shape helpers shared by the reduction pipeline
package reduce_tree_pkg;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NAND} op_e;
  function automatic int stages(int width, int fanin);
    int s = 0;
    int w = width;
    while (w > 1) begin
      w = (w + fanin - 1) / fanin;
      s++;
    end
    return s < 1 ? 1 : s;
  endfunction
  function automatic int level_width(int width, int fanin, int k);
    int w = width;
    for (int i = 0; i <= k; i++) w = (w + fanin - 1) / fanin;
    return w;
  endfunction
  function automatic logic identity(op_e op);
    return op == OP_AND || op == OP_NAND;
  endfunction
endpackage

// File: rtl/reduce_tree_stage.sv
// reduce_tree_stage: one tree level of FANIN-to-1 nodes with identity padding and a valid/op/data register
module reduce_tree_stage
  import reduce_tree_pkg::*;
#(
  parameter int IN_W = 8,
  parameter int FANIN = 2,
  localparam int OUT_W = (IN_W + FANIN - 1) / FANIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_data_i,
  input  op_e              in_op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output op_e              out_op_o
);
  localparam int PAD_W = OUT_W * FANIN;
  logic             valid_q, valid_d, load;
  op_e              op_q;
  logic [OUT_W-1:0] data_q, data_d;
  logic [PAD_W-1:0] pad;
  function automatic logic node(logic [FANIN-1:0] g, op_e op);
    return op == OP_OR ? |g : op == OP_XOR ? ^g : &g;
  endfunction
  assign in_ready_o  = !valid_q || out_ready_i;
  assign load        = in_valid_i && in_ready_o;
  assign valid_d     = load || (valid_q && !out_ready_i);
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_op_o    = op_q;
  // Pad the level to whole nodes with the op's identity element, then reduce each node
  always_comb begin
    pad = {PAD_W{identity(in_op_i)}};
    pad[IN_W-1:0] = in_data_i;
    for (int n = 0; n < OUT_W; n++) data_d[n] = node(pad[n*FANIN +: FANIN], in_op_i);
  end
  // Stage register: valid clears asynchronously, payload loads only on a transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op_q    <= OP_AND;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        op_q   <= in_op_i;
        data_q <= data_d;
      end
    end
  end
endmodule

// File: rtl/reduce_tree_pipe.sv
// reduce_tree_pipe: pipelined AND/OR/XOR/NAND reduction tree with valid/ready; REDUCE_TREE_OUT_REG_EN adds an output register
module reduce_tree_pipe
  import reduce_tree_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FANIN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [1:0]       in_op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_data_o,
  output logic [1:0]       out_op_o
);
  localparam int S = stages(WIDTH, FANIN);
  logic vld [S+1];
  logic rdy [S+1];
  op_e  ops [S+1];
  logic tail;
  assign vld[0]     = in_valid_i;
  assign ops[0]     = op_e'(in_op_i);
  assign in_ready_o = rdy[0];
  for (genvar k = 0; k < S; k++) begin : g_st
    localparam int IW = level_width(WIDTH, FANIN, k - 1);
    localparam int OW = level_width(WIDTH, FANIN, k);
    logic [IW-1:0] src;
    logic [OW-1:0] d;
    if (k == 0) begin : g_src
      assign src = in_data_i;
    end else begin : g_src
      assign src = g_st[k-1].d;
    end
    reduce_tree_stage #(.IN_W(IW), .FANIN(FANIN)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (vld[k]),
      .in_ready_o (rdy[k]),
      .in_data_i  (src),
      .in_op_i    (ops[k]),
      .out_valid_o(vld[k+1]),
      .out_ready_i(rdy[k+1]),
      .out_data_o (d),
      .out_op_o   (ops[k+1])
    );
  end
  assign tail = g_st[S-1].d[0] ^ (ops[S] == OP_NAND);
`ifdef REDUCE_TREE_OUT_REG_EN
  logic ov_q, ov_d, od_q;
  op_e  oop_q;
  assign rdy[S]      = !ov_q || out_ready_i;
  assign ov_d        = vld[S] || (ov_q && !out_ready_i);
  assign out_valid_o = ov_q;
  assign out_data_o  = od_q;
  assign out_op_o    = oop_q;
  // Output register: takes the inverted NAND result so out_data comes straight from a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q  <= 1'b0;
      od_q  <= 1'b0;
      oop_q <= OP_AND;
    end else begin
      ov_q <= ov_d;
      if (vld[S] && rdy[S]) begin
        od_q  <= tail;
        oop_q <= ops[S];
      end
    end
  end
`else
  assign rdy[S]      = out_ready_i;
  assign out_valid_o = vld[S];
  assign out_data_o  = tail;
  assign out_op_o    = ops[S];
`endif
endmodule

// File: tb/tb_reduce_tree_pipe.sv
// tb_reduce_tree_pipe: directed table vectors plus handshake corner cases and a scoreboarded random run
module tb_reduce_tree_pipe;
`ifdef REDUCE_TREE_OUT_REG_EN
  localparam int X = 1;
`else
  localparam int X = 0;
`endif
  localparam int SA = 3;
  localparam int SB = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic       a_iv = 1'b0, a_or = 1'b0, a_ir, a_ov, a_od;
  logic [7:0] a_id = '0;
  logic [1:0] a_iop = '0, a_oop;
  logic       b_iv = 1'b0, b_or = 1'b0, b_ir, b_ov, b_od;
  logic [8:0] b_id = '0;
  logic [1:0] b_iop = '0, b_oop;
  int checks = 0, failures = 0, cyc_n = 0, pops = 0, got_lat = 0;
  logic hold = 1'b0, hd = 1'b0, got = 1'b0, got_d = 1'b0, acc = 1'b0;
  logic [1:0] hop = '0, got_op = '0;
  typedef struct { logic d; logic [1:0] op; int cyc; } exp_t;
  exp_t exp_q[$];
  typedef struct { logic [7:0] d; logic [1:0] op; logic exp; } vec_t;
  vec_t tab [14];
  typedef struct { logic [8:0] d; logic [1:0] op; logic exp; } vecb_t;
  vecb_t tabb [7];
  logic [7:0] bp_d [5];

  reduce_tree_pipe #(.WIDTH(8), .FANIN(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_id), .in_op_i(a_iop),
    .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_od), .out_op_o(a_oop)
  );
  reduce_tree_pipe #(.WIDTH(9), .FANIN(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_id), .in_op_i(b_iop),
    .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_od), .out_op_o(b_oop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic gold(input logic [8:0] d, input int w, input logic [1:0] op);
    logic a = 1'b1, o = 1'b0, x = 1'b0;
    for (int i = 0; i < w; i++) begin
      a &= d[i];
      o |= d[i];
      x ^= d[i];
    end
    return op == 2'd0 ? a : op == 2'd1 ? o : op == 2'd2 ? x : !a;
  endfunction

  // one cycle on DUT A: drive at negedge, sample 1ns later, scoreboard transfers that the next posedge performs
  task automatic cyc_a(input logic iv, input logic [7:0] d, input logic [1:0] op, input logic ordy);
    exp_t e;
    @(negedge clk);
    a_iv = iv; a_id = d; a_iop = op; a_or = ordy;
    #1;
    if (hold) begin
      chk("hold_valid", a_ov, 1);
      chk("hold_data", a_od, hd);
      chk("hold_op", a_oop, hop);
    end
    got = 1'b0;
    acc = a_iv && a_ir;
    if (a_ov && a_or) begin
      got = 1'b1; got_d = a_od; got_op = a_oop; pops++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: out_data=%0d out_op=%0d with nothing outstanding", a_od, a_oop);
      end else begin
        e = exp_q.pop_front();
        got_lat = cyc_n - e.cyc;
        chk("sb_data", a_od, e.d);
        chk("sb_op", a_oop, e.op);
      end
    end
    if (acc) exp_q.push_back('{gold({1'b0, d}, 8, op), op, cyc_n});
    hold = a_ov && !a_or; hd = a_od; hop = a_oop;
    cyc_n++;
  endtask

  task automatic xfer_a(input logic [7:0] d, input logic [1:0] op, output logic r, output logic [1:0] rop, output int lat);
    int n = 0;
    cyc_a(1'b1, d, op, 1'b1);
    while (!acc && n < 20) begin
      cyc_a(1'b1, d, op, 1'b1);
      n++;
    end
    n = 0;
    cyc_a(1'b0, '0, '0, 1'b1);
    while (!got && n < 20) begin
      cyc_a(1'b0, '0, '0, 1'b1);
      n++;
    end
    r = got ? got_d : 1'bx;
    rop = got_op;
    lat = got ? got_lat : -1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      cyc_a(1'b0, '0, '0, 1'b1);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic xfer_b(input logic [8:0] d, input logic [1:0] op, output logic r, output logic [1:0] rop, output int lat);
    @(negedge clk);
    b_iv = 1'b1; b_id = d; b_iop = op; b_or = 1'b1;
    #1;
    chk("b_accept", b_ir, 1);
    @(negedge clk);
    b_iv = 1'b0;
    lat = 1;
    #1;
    while (!b_ov && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    r = b_ov ? b_od : 1'bx;
    rop = b_oop;
  endtask

  initial begin
    logic r;
    logic [1:0] rop;
    int lat, k;
    tab[0]  = '{8'hFF, 2'd0, 1'b1};  tab[1]  = '{8'hFE, 2'd0, 1'b0};
    tab[2]  = '{8'h00, 2'd1, 1'b0};  tab[3]  = '{8'h07, 2'd2, 1'b1};
    tab[4]  = '{8'hFF, 2'd3, 1'b0};  tab[5]  = '{8'h01, 2'd1, 1'b1};
    tab[6]  = '{8'h80, 2'd2, 1'b1};  tab[7]  = '{8'h03, 2'd2, 1'b0};
    tab[8]  = '{8'h00, 2'd3, 1'b1};  tab[9]  = '{8'hAA, 2'd2, 1'b0};
    tab[10] = '{8'h7F, 2'd3, 1'b1};  tab[11] = '{8'h10, 2'd0, 1'b0};
    tab[12] = '{8'h81, 2'd1, 1'b1};  tab[13] = '{8'hFF, 2'd2, 1'b0};
    tabb[0] = '{9'h1FF, 2'd0, 1'b1}; tabb[1] = '{9'h100, 2'd1, 1'b1};
    tabb[2] = '{9'h0FF, 2'd0, 1'b0}; tabb[3] = '{9'h1FF, 2'd2, 1'b1};
    tabb[4] = '{9'h100, 2'd2, 1'b1}; tabb[5] = '{9'h1FF, 2'd3, 1'b0};
    tabb[6] = '{9'h000, 2'd3, 1'b1};
    bp_d[0] = 8'hFF; bp_d[1] = 8'h0F; bp_d[2] = 8'h01; bp_d[3] = 8'hFF; bp_d[4] = 8'h3C;
    #12;
    chk("rst_in_ready", a_ir, 1);
    chk("rst_out_valid", a_ov, 0);
    chk("rst_out_data", a_od, 0);
    chk("rst_out_op", a_oop, 0);
    chk("rst_b_in_ready", b_ir, 1);
    chk("rst_b_out_valid", b_ov, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      xfer_a(tab[i].d, tab[i].op, r, rop, lat);
      chk($sformatf("tab%0d_data", i), r, tab[i].exp);
      chk($sformatf("tab%0d_op", i), rop, tab[i].op);
      chk($sformatf("tab%0d_latency", i), lat, SA + X);
    end
    k = 0;
    for (int i = 0; i < 10; i++)
      for (int o = 0; o < 4; o++) begin
        cyc_a(1'b1, i == 0 ? 8'h00 : i == 9 ? 8'hFF : 8'(1 << (i - 1)), 2'(o), 1'b1);
        if (acc) k++;
      end
    chk("stream_accepts", k, 40);
    drain();
    pops = 0; k = 0;
    for (int i = 0; i < 10; i++) begin
      cyc_a(k < 5, bp_d[k % 5], 2'(k), 1'b0);
      if (acc) k++;
    end
    chk("stall_accepts", k, SA + X);
    chk("stall_in_ready", a_ir, 0);
    chk("stall_out_valid", a_ov, 1);
    cyc_a(1'b1, bp_d[k], 2'(k), 1'b1);
    chk("shift_accept", acc, 1);
    if (acc) k++;
    for (int i = 0; i < 20 && k < 5; i++) begin
      cyc_a(1'b1, bp_d[k], 2'(k), 1'b1);
      if (acc) k++;
    end
    drain();
    chk("stall_pops", pops, 5);
    pops = 0; k = 0;
    cyc_a(1'b1, 8'h0F, 2'd1, 1'b0);
    for (int i = 0; i < 6; i++) cyc_a(1'b0, '0, '0, 1'b0);
    chk("bubble_stalled", a_ov, 1);
    for (int i = 0; i < 8; i++) begin
      cyc_a(1'b1, 8'hF0, 2'd2, 1'b0);
      if (acc) k++;
    end
    chk("bubble_accepts", k, SA + X - 1);
    drain();
    chk("bubble_pops", pops, k + 1);
    cyc_a(1'b1, 8'hFF, 2'd0, 1'b0);
    for (int i = 0; i < 6; i++) cyc_a(1'b0, '0, '0, 1'b0);
    cyc_a(1'b1, 8'h00, 2'd1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", a_ov, 0);
    chk("rst_async_ready", a_ir, 1);
    exp_q.delete();
    hold = 1'b0;
    a_iv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pops = 0;
    cyc_a(1'b1, 8'h0F, 2'd2, 1'b1);
    chk("rst_first_accept", acc, 1);
    drain();
    for (int i = 0; i < 6; i++) cyc_a(1'b0, '0, '0, 1'b1);
    chk("rst_no_stale", pops, 1);
    for (int i = 0; i < 7; i++) begin
      xfer_b(tabb[i].d, tabb[i].op, r, rop, lat);
      chk($sformatf("b%0d_data", i), r, tabb[i].exp);
      chk($sformatf("b%0d_op", i), rop, tabb[i].op);
      chk($sformatf("b%0d_latency", i), lat, SB + X);
    end
    for (int i = 0; i < 3000; i++)
      cyc_a(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom), $urandom_range(0, 3) != 0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
